// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one LIFO stack among NREQ requesters, with lock bursts.
// Define STACK_ARB_OCC_EN to add the DPT parameter and the o_occupancy/o_hiwat outputs.
module stack_arbiter #(
    parameter int NREQ = 4,
    parameter int DW = 8
`ifdef STACK_ARB_OCC_EN
    , parameter int DPT = 4
`endif
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ-1:0]          i_req_op,
    input  logic [NREQ*DW-1:0]       i_req_data,
    input  logic [NREQ-1:0]          i_req_lock,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [DW-1:0]            o_rsp_data,
    output logic                     o_lock_active,
    output logic [$clog2(NREQ)-1:0]  o_lock_owner,
    output logic                     o_stk_push_en,
    output logic [DW-1:0]            o_stk_push_data,
    output logic                     o_stk_pop_en,
    input  logic [DW-1:0]            i_stk_pop_data,
    input  logic                     i_stk_full,
    input  logic                     i_stk_empty
`ifdef STACK_ARB_OCC_EN
    , output logic [$clog2(DPT):0]   o_occupancy,
    output logic [$clog2(DPT):0]     o_hiwat
`endif
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, owner, g, idx;
    logic [NREQ-1:0] elig;
    logic [DW-1:0]   req_data [NREQ];
    logic            found, xfer, lock_exit;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    for (genvar d = 0; d < NREQ; d++) begin : g_data
        assign req_data[d] = i_req_data[d*DW +: DW];
    end

    // While locked, only the owner competes; everyone else stalls regardless of stack state.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = i_req_valid[i] & (i_req_op[i] ? ~i_stk_full : ~i_stk_empty)
                      & ((state == IDLE) | (owner == IDW'(i)));
    end

    always_comb begin
        found = 1'b0;
        g = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
    end

    assign xfer            = found & aresetn;
    assign lock_exit       = (state == LOCKED) & ~i_req_lock[owner];
    assign o_req_ready     = xfer ? (NREQ'(1) << g) : '0;
    assign o_stk_push_en   = xfer & i_req_op[g];
    assign o_stk_pop_en    = xfer & ~i_req_op[g];
    assign o_stk_push_data = req_data[g];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? ((xfer && i_req_lock[g]) ? LOCKED : IDLE)
                                    : (lock_exit ? IDLE : LOCKED);
    end

    always_comb begin
        o_lock_active = (state == LOCKED);
        o_lock_owner  = o_lock_active ? owner : '0;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr      <= '0;
            owner       <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            if (state == IDLE && xfer)
                rr_ptr <= wrap_inc(g);
            else if (lock_exit)
                rr_ptr <= wrap_inc(owner);
            if (state == IDLE && xfer && i_req_lock[g])
                owner <= g;
            o_rsp_valid <= o_stk_pop_en ? (NREQ'(1) << g) : '0;
            if (o_stk_pop_en)
                o_rsp_data <= i_stk_pop_data;
        end
    end

`ifdef STACK_ARB_OCC_EN
    localparam int OW = $clog2(DPT) + 1;

    logic [OW-1:0] occ_nxt;

    always_comb begin
        occ_nxt = o_occupancy;
        if (o_stk_push_en && o_occupancy != OW'(DPT))
            occ_nxt = o_occupancy + 1'b1;
        else if (o_stk_pop_en && o_occupancy != '0)
            occ_nxt = o_occupancy - 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_occupancy <= '0;
            o_hiwat     <= '0;
        end else begin
            o_occupancy <= occ_nxt;
            if (occ_nxt > o_hiwat)
                o_hiwat <= occ_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed self-checking bench for stack_arbiter (default build, NREQ=4, DW=8).
// A small behavioural LIFO with adjustable depth sits on the stack side.
module tb_stack_arbiter;
    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  req_valid, req_op, req_lock;
    logic [31:0] req_data;
    logic [3:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_data, stk_push_data, stk_pop_data;
    logic        lock_active, stk_push_en, stk_pop_en, stk_full, stk_empty;
    logic [1:0]  lock_owner;

    int checks = 0;
    int errors = 0;

    logic [7:0] stk [8];
    int         sp;
    int         depth;
    logic       stk_clr;

    stack_arbiter #(.NREQ(4), .DW(8)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .i_req_valid(req_valid),
        .i_req_op(req_op),
        .i_req_data(req_data),
        .i_req_lock(req_lock),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data),
        .o_lock_active(lock_active),
        .o_lock_owner(lock_owner),
        .o_stk_push_en(stk_push_en),
        .o_stk_push_data(stk_push_data),
        .o_stk_pop_en(stk_pop_en),
        .i_stk_pop_data(stk_pop_data),
        .i_stk_full(stk_full),
        .i_stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stk_clr)
            sp <= 0;
        else if (stk_push_en) begin
            stk[sp] <= stk_push_data;
            sp <= sp + 1;
        end else if (stk_pop_en)
            sp <= sp - 1;
    end

    assign stk_full     = sp >= depth;
    assign stk_empty    = sp == 0;
    assign stk_pop_data = (sp > 0) ? stk[sp-1] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    initial begin
        aresetn = 1'b0;
        stk_clr = 1'b1;
        depth = 4;
        req_valid = 4'hF;
        req_op = 4'hF;
        req_lock = 4'h0;
        req_data = 32'h13121110;
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_push_en", stk_push_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_lock_active", lock_active, 1'b0);
        chk("rst_lock_owner", lock_owner, 2'd0);
        step;
        step;
        aresetn = 1'b1;
        stk_clr = 1'b0;
        depth = 8;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", req_ready, rr_g[k]);
            chk("rr_data", stk_push_data, rr_d[k]);
            step;
        end
        req_valid = 4'h0;
        stk_clr = 1'b1;
        step;
        stk_clr = 1'b0;
        depth = 4;

        req_valid = 4'b0010; req_op = 4'b0010; req_data = 32'h0000A500;
        #1;
        chk("pr_push_ready", req_ready, 4'b0010);
        chk("pr_push_en", stk_push_en, 1'b1);
        chk("pr_push_data", stk_push_data, 8'hA5);
        step;
        req_valid = 4'b0100; req_op = 4'b0000; req_data = 32'h0;
        #1;
        chk("pr_pop_ready", req_ready, 4'b0100);
        chk("pr_pop_en", stk_pop_en, 1'b1);
        chk("pr_no_push", stk_push_en, 1'b0);
        step;
        req_valid = 4'b0000;
        #1;
        chk("pr_rsp_valid", rsp_valid, 4'b0100);
        chk("pr_rsp_data", rsp_data, 8'hA5);
        step;
        chk("pr_rsp_drop", rsp_valid, 4'b0000);

        req_valid = 4'b0001; req_op = 4'b0000;
        #1;
        chk("empty_stall", req_ready, 4'b0000);
        step;
        chk("empty_stall_hold", req_ready, 4'b0000);
        req_valid = 4'b0101; req_op = 4'b0100; req_data = 32'h00770000;
        #1;
        chk("empty_push_ok", req_ready, 4'b0100);
        step;
        req_valid = 4'b0010; req_op = 4'b0010; req_data = 32'h00002100;
        step;
        step;
        step;
        req_valid = 4'b1001; req_op = 4'b0001; req_data = 32'h000000EE;
        #1;
        chk("full_ready", req_ready, 4'b1000);
        chk("full_no_push", stk_push_en, 1'b0);
        chk("full_pop_en", stk_pop_en, 1'b1);
        step;
        req_valid = 4'b0000;
        chk("full_rsp_valid", rsp_valid, 4'b1000);
        chk("full_rsp_data", rsp_data, 8'h21);
        stk_clr = 1'b1;
        step;
        stk_clr = 1'b0;

        req_valid = 4'b0100; req_op = 4'b0100; req_lock = 4'b0100; req_data = 32'h00300000;
        #1;
        chk("lock_first", req_ready, 4'b0100);
        step;
        chk("lock_active", lock_active, 1'b1);
        chk("lock_owner", lock_owner, 2'd2);
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0111;
            req_data = (32'h31 + 32'(k)) << 16;
            #1;
            chk("lock_burst", req_ready, 4'b0100);
            step;
        end
        req_lock = 4'b0000; req_valid = 4'b0011;
        #1;
        chk("lock_rel_stall", req_ready, 4'b0000);
        step;
        chk("lock_rel_active", lock_active, 1'b0);
        chk("lock_rel_owner", lock_owner, 2'd0);
        #1;
        chk("after_lock_req0", req_ready, 4'b0001);
        req_valid = 4'b1011;
        #1;
        chk("after_lock_req3", req_ready, 4'b1000);
        step;
        req_valid = 4'b0000;
        chk("after_lock_rsp", rsp_valid, 4'b1000);
        chk("after_lock_data", rsp_data, 8'h33);

        req_valid = 4'b0010; req_op = 4'b0010; req_lock = 4'b0010; req_data = 32'h00004400;
        #1;
        chk("idle_lock_grant", req_ready, 4'b0010);
        step;
        chk("idle_lock_owner", lock_owner, 2'd1);
        req_valid = 4'b1001; req_op = 4'b0000;
        #1;
        chk("idle_lock_others", req_ready, 4'b0000);
        step;
        chk("idle_lock_hold", lock_active, 1'b1);
        req_lock = 4'b0000;
        #1;
        chk("idle_rel_cycle", req_ready, 4'b0000);
        step;
        chk("idle_rel_active", lock_active, 1'b0);
        chk("idle_rel_grant", req_ready, 4'b1000);
        step;
        chk("idle_rel_rsp", rsp_valid, 4'b1000);
        chk("idle_rel_data", rsp_data, 8'h44);

        req_valid = 4'b0001; req_op = 4'b0000; req_lock = 4'b0001;
        #1;
        chk("ar_lock_grant", req_ready, 4'b0001);
        step;
        chk("ar_rsp_pending", rsp_valid, 4'b0001);
        chk("ar_locked", lock_active, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("ar_ready", req_ready, 4'b0000);
        chk("ar_pop_en", stk_pop_en, 1'b0);
        chk("ar_push_en", stk_push_en, 1'b0);
        chk("ar_rsp_valid", rsp_valid, 4'b0000);
        chk("ar_rsp_data", rsp_data, 8'h00);
        chk("ar_lock_active", lock_active, 1'b0);
        step;
        aresetn = 1'b1;
        req_valid = 4'hF; req_op = 4'h0; req_lock = 4'h0;
        #1;
        chk("ar_post_grant", req_ready, 4'b0001);
        chk("ar_post_lock", lock_active, 1'b0);
        step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack instance (depth DPT, width DW) between NREQ requesters.
- Each requester issues push or pop requests over a valid/ready handshake.
- The arbiter grants one operation per cycle using round-robin priority and drives the stack's push/pop enables.
- Pop data returns as a one-cycle registered response to the requester that popped.
- An optional lock lets one requester keep the stack for an atomic burst of operations.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data width; must match the stack.
- IDW, $clog2(NREQ), requester index width (localparam).

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous reset, active-low
- i_req_valid  in  NREQ  request valid, one bit per requester
- i_req_op  in  NREQ  per requester: 1=push, 0=pop
- i_req_data  in  NREQ*DW  push data; requester i occupies bits [i*DW +: DW]
- i_req_lock  in  NREQ  per requester: request or hold exclusive lock
- o_req_ready  out  NREQ  grant/accept, at most one bit set
- o_rsp_valid  out  NREQ  pop response pulse, one-hot
- o_rsp_data  out  DW  pop response data
- o_lock_active  out  1  a lock is currently held
- o_lock_owner  out  IDW  index of the lock holder
- o_stk_push_en  out  1  to stack push enable
- o_stk_push_data  out  DW  to stack push data
- o_stk_pop_en  out  1  to stack pop enable
- i_stk_pop_data  in  DW  from stack; combinational top-of-stack item
- i_stk_full  in  1  from stack full flag
- i_stk_empty  in  1  from stack empty flag

Behaviour:
- Reset state: all registered outputs 0, RR pointer 0, FSM in IDLE.
- While aresetn=0, o_req_ready, o_stk_push_en and o_stk_pop_en are held at 0.
- Eligibility: elig[i] = i_req_valid[i] & (i_req_op[i] ? ~i_stk_full : ~i_stk_empty).
  - Ineligible requests stall; they are never dropped or errored.
- Arbitration is combinational in the same cycle.
  - The first eligible index searching upward from rr_ptr (modulo NREQ) gets o_req_ready.
  - Transfer = i_req_valid[g] & o_req_ready[g].
- Stack drive:
  - o_stk_push_en = transfer & push.
  - o_stk_pop_en = transfer & pop.
  - o_stk_push_data = data slice of the granted requester.
  - The arbiter never asserts push and pop in the same cycle.
- RR pointer: after a transfer by g in IDLE, rr_ptr <= (g+1) mod NREQ. No update when there is no transfer.
- FSM states: IDLE, LOCKED.
  - IDLE -> LOCKED on a transfer by g with i_req_lock[g]=1; owner <= g.
  - In LOCKED, only the owner is eligible for arbitration. Others stall even if the stack could serve them.
  - LOCKED -> IDLE when the owner's i_req_lock is sampled 0, with or without a transfer.
    - A transfer in that same cycle is still served.
    - On exit, rr_ptr <= (owner+1) mod NREQ.
  - The owner may idle (valid=0) while locked; the lock persists.
- o_lock_active is 1 in LOCKED. o_lock_owner is valid only when o_lock_active=1 and is 0 otherwise.
- Pop response:
  - A pop transfer by g in cycle T gives o_rsp_valid[g]=1 at T+1 for exactly one cycle.
  - o_rsp_data = i_stk_pop_data registered at T.
  - There is no backpressure on responses; back-to-back pops give back-to-back pulses.
  - Push transfers produce no response.
- Boundaries:
  - Full stack: pushes stall and pops proceed.
  - Empty stack: pops stall and pushes proceed.
  - A pop-on-empty stall by the lock owner deadlocks only that owner's pops; releasing the lock frees the others.
- Reset mid-operation: lock cleared, pending response pulse dropped, pointer returns to 0.

Optional Feature:
- Macro: STACK_ARB_OCC_EN.
- With the macro defined:
  - Adds outputs o_occupancy [$clog2(DPT):0] and o_hiwat [$clog2(DPT):0], plus parameter DPT (default 4).
  - The occupancy counter is +1 on a push transfer and -1 on a pop transfer.
  - o_hiwat holds the maximum occupancy seen since reset.
  - Both reset to 0 and saturate at DPT.
- Without the macro: neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Round-robin order: NREQ=4, all four requesters push continuously with data 0x10..0x13, stack not full -> grants 0,1,2,3,0 on consecutive cycles.
- Pop response: push 0xA5 from req1; next cycle req2 pops -> o_rsp_valid=4'b0100 one cycle later with o_rsp_data=0xA5; o_rsp_valid deasserts the cycle after.
- Full and empty stalls: fill the stack to DPT=4; req0 push and req3 pop both valid -> req3 granted, req0 ready=0. On an empty stack, a lone pop gets ready=0 indefinitely.
- Lock burst: req2 pushes with lock=1, then 3 more pushes while req0 and req1 are valid -> only req2 granted. Req2 drops lock -> next grant goes to req3 if valid, else req0.
- Lock release without transfer: owner req1 sets valid=0 and lock=0 -> o_lock_active falls next cycle; other requesters are granted.
- Async reset mid-burst: assert aresetn=0 during LOCKED with a response pending -> ready, stack enables and o_rsp_valid go to 0 immediately; after release, grant starts from req0.
